// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scans a 4x4 active-low matrix keypad and publishes
// the complete 16-bit key map once per full scan. No debounce and no
// multi-key resolution; the downstream jitter controller handles both.
//
// Handshake: scan_valid is a single-cycle pulse with no ready/back-pressure.
// It is high in exactly the cycle in which a newly published keys_pressed
// first appears. keys_pressed stays stable until the next pulse.
module keypad_scanner #(
    parameter int SETTLE_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  rows,
    output logic [3:0]  cols,
    output logic [15:0] keys_pressed,
    output logic        scan_valid
);

    localparam int            CW       = $clog2(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2,
        COL3 = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    sync1_q, sync2_q;
    logic [11:0]   shadow_q, shadow_d;
    logic [15:0]   keys_q, keys_d;
    logic          valid_q, valid_d;
    logic          sample_edge;
    logic [3:0]    pressed_col;

    // The last settle count marks the edge on which the driven column is sampled.
    assign sample_edge = (cnt_q == CNT_LAST);
    assign pressed_col = ~sync2_q;

    // Two-flop synchronizer on the asynchronous row lines. The reset value is idle (no key).
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
        end else begin
            sync1_q <= rows;
            sync2_q <= sync1_q;
        end
    end

    // State, settle counter, shadow and published map registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= COL0;
            cnt_q    <= '0;
            shadow_q <= '0;
            keys_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            keys_q   <= keys_d;
            valid_q  <= valid_d;
        end
    end

    // Next state, shadow capture and publish. The column drive is decoded from the current state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        shadow_d = shadow_q;
        keys_d   = keys_q;
        valid_d  = 1'b0;
        cols     = 4'b1110;

        case (state_q)
            COL0:    cols = 4'b1110;
            COL1:    cols = 4'b1101;
            COL2:    cols = 4'b1011;
            COL3:    cols = 4'b0111;
            default: cols = 4'b1110;
        endcase

        if (sample_edge) begin
            cnt_d = '0;
            case (state_q)
                COL0: begin
                    state_d        = COL1;
                    shadow_d[3:0]  = pressed_col;
                end
                COL1: begin
                    state_d        = COL2;
                    shadow_d[7:4]  = pressed_col;
                end
                COL2: begin
                    state_d        = COL3;
                    shadow_d[11:8] = pressed_col;
                end
                COL3: begin
                    // Publish the whole map at once so that a partial scan never shows.
                    state_d = COL0;
                    keys_d  = {pressed_col, shadow_q};
                    valid_d = 1'b1;
                end
                default: state_d = COL0;
            endcase
        end
    end

    assign keys_pressed = keys_q;
    assign scan_valid   = valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed testbench for keypad_scanner with SETTLE_CYCLES = 4 (scan period 16).
// A behavioural keypad pulls row r low while column c is driven and key_mat[4c+r] is set.
module tb_keypad_scanner;

    localparam int S      = 4;
    localparam int PERIOD = 4 * S;

    logic        clk;
    logic        reset;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [15:0] keys_pressed;
    logic        scan_valid;
    logic [15:0] key_mat;

    int tests_run;
    int tests_failed;

    keypad_scanner #(.SETTLE_CYCLES(S)) dut (
        .clk          (clk),
        .reset        (reset),
        .rows         (rows),
        .cols         (cols),
        .keys_pressed (keys_pressed),
        .scan_valid   (scan_valid)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: a closed key connects its driven-low column to its row.
    always_comb begin
        rows = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (key_mat[4*c+r] && !cols[c]) rows[r] = 1'b0;
            end
        end
    end

    // Advance one clock edge, then settle 1 ns away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected column drive after tick i following a pulse or a reset release.
    function automatic logic [3:0] exp_cols(input int i);
        logic [3:0] tbl [4];
        tbl[0] = 4'b1110; tbl[1] = 4'b1101; tbl[2] = 4'b1011; tbl[3] = 4'b0111;
        return tbl[(i / S) % 4];
    endfunction

    task automatic test_reset();
        reset   = 1'b0;
        key_mat = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (cols !== 4'b1110 || keys_pressed !== 16'h0000 || scan_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold cycle %0d: cols=%b keys=%h valid=%b, need 1110/0000/0", i, cols, keys_pressed, scan_valid);
            end
        end
        reset = 1'b1;
        for (int i = 1; i <= PERIOD; i++) begin
            tick();
            tests_run++;
            if (cols !== exp_cols(i) || scan_valid !== (i == PERIOD)) begin
                tests_failed++;
                $display("FAIL idle_seq tick %0d: cols=%b valid=%b, need %b/%b", i, cols, scan_valid, exp_cols(i), (i == PERIOD));
            end
        end
        tests_run++;
        if (keys_pressed !== 16'h0000) begin
            tests_failed++;
            $display("FAIL idle_keys: got %h need 0000", keys_pressed);
        end
    endtask

    task automatic test_single_key();
        key_mat = 16'h0040;
        for (int scan = 0; scan < 2; scan++) begin
            for (int i = 1; i <= PERIOD; i++) begin
                tick();
                if (i < PERIOD && scan == 1) begin
                    tests_run++;
                    if (keys_pressed !== 16'h0040 || scan_valid !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL single_hold tick %0d: keys=%h valid=%b, need 0040/0", i, keys_pressed, scan_valid);
                    end
                end
            end
            tests_run++;
            if (scan_valid !== 1'b1 || keys_pressed !== 16'h0040) begin
                tests_failed++;
                $display("FAIL single_pub scan %0d: keys=%h valid=%b, need 0040/1", scan, keys_pressed, scan_valid);
            end
        end
    endtask

    task automatic test_multi_key();
        key_mat = 16'h8001;
        for (int i = 1; i < PERIOD; i++) tick();
        tests_run++;
        if (keys_pressed !== 16'h0040 || scan_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL multi_no_partial: keys=%h valid=%b, need 0040/0", keys_pressed, scan_valid);
        end
        tick();
        tests_run++;
        if (scan_valid !== 1'b1 || keys_pressed !== 16'h8001) begin
            tests_failed++;
            $display("FAIL multi_pub: keys=%h valid=%b, need 8001/1", keys_pressed, scan_valid);
        end
    endtask

    task automatic test_release_mid();
        key_mat = 16'h0200;
        for (int i = 1; i <= 3 * S; i++) tick();
        key_mat = 16'h0000;
        for (int i = 3 * S + 1; i <= PERIOD; i++) tick();
        tests_run++;
        if (scan_valid !== 1'b1 || keys_pressed !== 16'h0200) begin
            tests_failed++;
            $display("FAIL release_pub: keys=%h valid=%b, need 0200/1", keys_pressed, scan_valid);
        end
        for (int i = 1; i <= PERIOD; i++) tick();
        tests_run++;
        if (scan_valid !== 1'b1 || keys_pressed !== 16'h0000) begin
            tests_failed++;
            $display("FAIL release_next: keys=%h valid=%b, need 0000/1", keys_pressed, scan_valid);
        end
    endtask

    task automatic test_reset_mid();
        key_mat = 16'h0008;
        for (int i = 1; i <= PERIOD; i++) tick();
        tests_run++;
        if (scan_valid !== 1'b1 || keys_pressed !== 16'h0008) begin
            tests_failed++;
            $display("FAIL rmid_pre: keys=%h valid=%b, need 0008/1", keys_pressed, scan_valid);
        end
        // Move into COL2, then pulse reset for one edge.
        for (int i = 1; i <= 2 * S + 1; i++) tick();
        tests_run++;
        if (cols !== 4'b1011) begin
            tests_failed++;
            $display("FAIL rmid_in_col2: cols=%b need 1011", cols);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tests_run++;
        if (cols !== 4'b1110 || keys_pressed !== 16'h0000 || scan_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmid_reset: cols=%b keys=%h valid=%b, need 1110/0000/0", cols, keys_pressed, scan_valid);
        end
        for (int i = 1; i <= PERIOD; i++) begin
            tick();
            tests_run++;
            if (scan_valid !== (i == PERIOD) || cols !== exp_cols(i)) begin
                tests_failed++;
                $display("FAIL rmid_seq tick %0d: cols=%b valid=%b, need %b/%b", i, cols, scan_valid, exp_cols(i), (i == PERIOD));
            end
        end
        tests_run++;
        if (keys_pressed !== 16'h0008) begin
            tests_failed++;
            $display("FAIL rmid_pub: keys=%h need 0008", keys_pressed);
        end
    endtask

    task automatic test_periodicity();
        logic [15:0] vec [10];
        vec[0] = 16'h5A3C; vec[1] = 16'hFFFF; vec[2] = 16'h0001; vec[3] = 16'h8000;
        vec[4] = 16'h1248; vec[5] = 16'hF00F; vec[6] = 16'h0F0F; vec[7] = 16'h0000;
        vec[8] = 16'hA5A5; vec[9] = 16'h0420;
        for (int scan = 0; scan < 10; scan++) begin
            key_mat = vec[scan];
            for (int i = 1; i <= PERIOD; i++) begin
                tick();
                tests_run++;
                if ($countones(~cols) != 1 || cols !== exp_cols(i) || scan_valid !== (i == PERIOD)) begin
                    tests_failed++;
                    $display("FAIL period scan %0d tick %0d: cols=%b valid=%b, need %b/%b", scan, i, cols, scan_valid, exp_cols(i), (i == PERIOD));
                end
            end
            tests_run++;
            if (keys_pressed !== vec[scan]) begin
                tests_failed++;
                $display("FAIL period_keys scan %0d: got %h need %h", scan, keys_pressed, vec[scan]);
            end
        end
    endtask

    // Test sequence. Each test after test_reset starts right after a scan_valid pulse.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        key_mat      = 16'h0000;
        test_reset();
        test_single_key();
        test_multi_key();
        test_release_mid();
        test_reset_mid();
        test_periodicity();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
